// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer for a synchronous-read data BRAM.
// Aligns stores, waits out read latency, extends load data; busy stalls the pipe.
module mem_access_unit #(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_load_type,
    input  logic [3:0]        req_store_mask,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic              access_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STORE = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LH  = 3'd2;
    localparam logic [2:0] LT_LW  = 3'd3;
    localparam logic [2:0] LT_LBU = 3'd4;
    localparam logic [2:0] LT_LHU = 3'd5;
    localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-3:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_we_q, mem_we_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [2:0]          ld_type_q, ld_type_d;
    logic [1:0]          off_q, off_d;
    logic [4:0]          rd_q, rd_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [4:0]          resp_rd_q, resp_rd_d;
    logic                access_err_q, access_err_d;

    logic        accept, is_load, is_store, req_err, wait_done;
    logic        type_bad, mask_bad, is_half, is_word, misaligned;
    logic [1:0]  a_lo;
    logic [31:0] rshift, ld_ext;

    // Request classification, evaluated against the raw ID-stage controls.
    always_comb begin
        a_lo       = req_addr[1:0];
        is_load    = (req_load_type != 3'd0);
        is_store   = (req_store_mask != 4'd0);
        type_bad   = (req_load_type > LT_LHU);
        mask_bad   = !(req_store_mask == 4'b0000 || req_store_mask == 4'b0001 ||
                       req_store_mask == 4'b0011 || req_store_mask == 4'b1111);
        is_half    = (req_load_type == LT_LH) || (req_load_type == LT_LHU) ||
                     (req_store_mask == 4'b0011);
        is_word    = (req_load_type == LT_LW) || (req_store_mask == 4'b1111);
        misaligned = (is_half && a_lo[0]) || (is_word && (a_lo != 2'b00));
        req_err    = type_bad || mask_bad || (is_load && is_store) || misaligned;
        accept     = req_valid && (state_q == S_IDLE);
        wait_done  = (cnt_q == WAIT_LAST);
    end

    always_comb begin
        rshift = mem_rdata >> {off_q, 3'b000};
        case (ld_type_q)
            LT_LB:   ld_ext = {{24{rshift[7]}}, rshift[7:0]};
            LT_LH:   ld_ext = {{16{rshift[15]}}, rshift[15:0]};
            LT_LW:   ld_ext = mem_rdata;
            LT_LBU:  ld_ext = {24'd0, rshift[7:0]};
            LT_LHU:  ld_ext = {16'd0, rshift[15:0]};
            default: ld_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            mem_addr_q   <= '0;
            mem_we_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            ld_type_q    <= 3'd0;
            off_q        <= 2'd0;
            rd_q         <= 5'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_rd_q    <= 5'd0;
            access_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            ld_type_q    <= ld_type_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            access_err_q <= access_err_d;
        end
    end

    // WAIT spans the BRAM latency; read data is captured on its last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 2'd0;
                if (accept && !req_err) begin
                    if (is_store)     state_d = S_STORE;
                    else if (is_load) state_d = S_ISSUE;
                end
            end
            S_STORE: state_d = S_IDLE;
            S_ISSUE: begin
                cnt_d   = 2'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_done) state_d = S_RESP;
                else           cnt_d   = cnt_q + 2'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 4'd0;
        mem_wdata_d  = mem_wdata_q;
        ld_type_d    = ld_type_q;
        off_d        = off_q;
        rd_d         = rd_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        access_err_d = 1'b0;
        if (accept) begin
            if (req_err) begin
                access_err_d = 1'b1;
            end else if (is_store) begin
                mem_addr_d  = req_addr[ADDR_W-1:2];
                mem_we_d    = req_store_mask << a_lo;
                mem_wdata_d = req_wdata << {a_lo, 3'b000};
            end else if (is_load) begin
                mem_addr_d = req_addr[ADDR_W-1:2];
                ld_type_d  = req_load_type;
                off_d      = a_lo;
                rd_d       = req_rd;
            end
        end
        if (state_q == S_WAIT && wait_done) begin
            resp_valid_d = 1'b1;
            resp_data_d  = ld_ext;
            resp_rd_d    = rd_q;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = ~req_ready;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign access_err = access_err_q;

endmodule
